// File: rtl/des_pkg.sv
// Shared DES types, permutation tables, key-schedule constant and helpers.
// Table entries use DES numbering: entry value 1 names the MSB of the source word.
// Each table is packed 64 x 8 bits, first entry at index 63, zero-padded at the end.
package des_pkg;

  typedef logic [63:0] des_block_t;
  typedef logic [31:0] half_t;
  typedef logic [55:0] key56_t;
  typedef logic [47:0] subkey_t;

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  typedef logic [63:0][7:0] perm_tbl_t;

  localparam perm_tbl_t IP_TBL = {
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,  8'd60, 8'd52, 8'd44, 8'd36,
    8'd28, 8'd20, 8'd12, 8'd4,  8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
    8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,  8'd57, 8'd49, 8'd41, 8'd33,
    8'd25, 8'd17, 8'd9,  8'd1,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,  8'd63, 8'd55, 8'd47, 8'd39,
    8'd31, 8'd23, 8'd15, 8'd7
  };

  localparam perm_tbl_t FP_TBL = {
    8'd40, 8'd8,  8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32, 8'd39, 8'd7,  8'd47, 8'd15,
    8'd55, 8'd23, 8'd63, 8'd31, 8'd38, 8'd6,  8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
    8'd37, 8'd5,  8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29, 8'd36, 8'd4,  8'd44, 8'd12,
    8'd52, 8'd20, 8'd60, 8'd28, 8'd35, 8'd3,  8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
    8'd34, 8'd2,  8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26, 8'd33, 8'd1,  8'd41, 8'd9,
    8'd49, 8'd17, 8'd57, 8'd25
  };

  localparam perm_tbl_t E_TBL = {
    8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
    8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
    8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
    8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1,
    {16{8'd0}}
  };

  localparam perm_tbl_t P_TBL = {
    8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17, 8'd1,  8'd15, 8'd23, 8'd26,
    8'd5,  8'd18, 8'd31, 8'd10, 8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
    8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25,
    {32{8'd0}}
  };

  localparam perm_tbl_t PC1_TBL = {
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,  8'd58, 8'd50, 8'd42, 8'd34,
    8'd26, 8'd18, 8'd10, 8'd2,  8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd60, 8'd52, 8'd44, 8'd36, 8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37,
    8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4,
    {8{8'd0}}
  };

  localparam perm_tbl_t PC2_TBL = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28, 8'd15, 8'd6,  8'd21, 8'd10,
    8'd23, 8'd19, 8'd12, 8'd4,  8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40, 8'd51, 8'd45, 8'd33, 8'd48,
    8'd44, 8'd49, 8'd39, 8'd56, 8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32,
    {16{8'd0}}
  };

  // Bit (r-1) set: round r rotates by one position (rounds 1, 2, 9, 16), otherwise by two.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  // Generic bit permutation. The source occupies din[in_w-1:0]; the result is returned in
  // bits [out_w-1:0] with the upper bits zero.
  function automatic logic [63:0] apply_perm(input logic [63:0] din, input perm_tbl_t tbl,
                                             input int unsigned in_w, input int unsigned out_w);
    logic [63:0] res;
    logic [5:0]  dst;
    logic [5:0]  src;
    res = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < out_w) begin
        dst = 6'(out_w - 1 - i);
        src = 6'(in_w - 32'(tbl[6'(63 - i)]));
        res[dst] = din[src];
      end
    end
    return res;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic by_two);
    return by_two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic by_two);
    return by_two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R, K): expansion, subkey XOR, S-box substitution, P permutation.
//   r_i      [31:0] : right half entering the round
//   subkey_i [47:0] : round subkey
//   f_o      [31:0] : f-function result
module des_f_function
  import des_pkg::*;
(
  input  half_t   r_i,
  input  subkey_t subkey_i,
  output half_t   f_o
);

  subkey_t expanded;
  subkey_t mixed;
  half_t   sbox_out;

  assign expanded = 48'(apply_perm({32'h0, r_i}, E_TBL, 32, 48));
  assign mixed    = expanded ^ subkey_i;

  des_sbox u_sbox (
    .din_i  (mixed),
    .dout_o (sbox_out)
  );

  assign f_o = 32'(apply_perm({32'h0, sbox_out}, P_TBL, 32, 32));

endmodule

// File: rtl/des_sbox.sv
// DES S-box substitution: eight 6-to-4 lookups.
//   din_i  [47:0] : expanded-and-keyed half block, bits 47:42 feed S1
//   dout_o [31:0] : substituted output, bits 31:28 come from S1
module des_sbox (
  input  logic [47:0] din_i,
  output logic [31:0] dout_o
);

  // Each box is 64 nibbles in row-major order (row 0 col 0 in the top nibble).
  localparam logic [7:0][255:0] S_TBL = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  for (genvar gi = 0; gi < 8; gi++) begin : g_box
    logic [5:0] six;
    logic [5:0] idx;
    logic [7:0] msb;
    assign six = din_i[47 - 6 * gi -: 6];
    // Outer bits select the row, inner four the column.
    assign idx = {six[5], six[0], six[4:1]};
    assign msb = 8'd255 - {idx, 2'b00};
    assign dout_o[31 - 4 * gi -: 4] = S_TBL[7 - gi][msb -: 4];
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES controller: one Feistel round per clock, one shared f-function.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : job handshake; in_decrypt, in_key, in_block sampled on accept
//   out_valid / out_ready : result handshake; out_block held while stalled
//   busy                  : job in flight (ROUND or DONE)
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_key,
  input  logic [63:0] in_block,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy
);

  localparam logic [4:0] LastRound = 5'(ROUNDS);

  state_e      state_q, state_d;
  logic [4:0]  round_q, round_d;
  half_t       l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic        dec_q, dec_d;
  des_block_t  out_block_q, out_block_d;

  logic        accept;
  logic        last_round;
  logic [3:0]  sched_idx;
  logic        one_step;
  logic [27:0] c_rot, d_rot;
  des_block_t  ip_blk, fp_blk;
  key56_t      pc1_cd;
  subkey_t     subkey;
  half_t       f_out, r_next;

  assign accept     = in_valid & in_ready;
  assign last_round = (round_q == LastRound);
  // Round 16 wraps to index 15 through the 4-bit subtraction.
  assign sched_idx  = round_q[3:0] - 4'd1;
  assign one_step   = SHIFT_ONE[sched_idx];

  // Key-schedule rotation for the current round, applied before PC2. Decrypt starts from
  // C0/D0 == C16/D16, so round 1 uses the loaded value unrotated and later rounds undo
  // the encrypt schedule by rotating right.
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    if (!dec_q) begin
      c_rot = rotl28(c_q, !one_step);
      d_rot = rotl28(d_q, !one_step);
    end else if (round_q != 5'd1) begin
      c_rot = rotr28(c_q, !one_step);
      d_rot = rotr28(d_q, !one_step);
    end
  end

  assign subkey = 48'(apply_perm({8'h00, c_rot, d_rot}, PC2_TBL, 56, 48));

  des_f_function u_f (
    .r_i      (r_q),
    .subkey_i (subkey),
    .f_o      (f_out)
  );

  assign r_next = l_q ^ f_out;
  assign ip_blk = apply_perm(in_block, IP_TBL, 64, 64);
  assign pc1_cd = 56'(apply_perm(in_key, PC1_TBL, 64, 56));
  // Final swap: preoutput is {R16, L16}, and L16 is the outgoing R.
  assign fp_blk = apply_perm({r_next, r_q}, FP_TBL, 64, 64);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRound;
      StRound: if (last_round) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_block = out_block_q;
  end

  // Datapath next-state.
  always_comb begin
    round_d     = round_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    dec_d       = dec_q;
    out_block_d = out_block_q;
    if (accept) begin
      l_d     = ip_blk[63:32];
      r_d     = ip_blk[31:0];
      c_d     = pc1_cd[55:28];
      d_d     = pc1_cd[27:0];
      dec_d   = in_decrypt;
      round_d = 5'd1;
    end else if (state_q == StRound) begin
      l_d = r_q;
      r_d = r_next;
      c_d = c_rot;
      d_d = d_rot;
      if (last_round) begin
        out_block_d = fp_blk;
      end else begin
        round_d = round_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round_q     <= '0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      dec_q       <= 1'b0;
      out_block_q <= '0;
    end else begin
      round_q     <= round_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      dec_q       <= dec_d;
      out_block_q <= out_block_d;
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl: known-answer vector table plus directed
// sequences for backpressure, back-to-back jobs, reset mid-job and input stability.
module tb_des_round_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_decrypt;
  logic [63:0] in_key, in_block, out_block;
  logic        out_valid, out_ready, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          acc_cyc[$];
  int          res_cyc[$];
  logic [63:0] res_q[$];

  localparam logic [63:0] FipsKey = 64'h133457799BBCDFF1;
  localparam logic [63:0] FipsPt  = 64'h0123456789ABCDEF;
  localparam logic [63:0] FipsCt  = 64'h85E813540F0AB405;

  typedef struct {
    logic [63:0] key;
    logic [63:0] blk;
    logic        dec;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6];

  des_round_ctrl #(.ROUNDS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_decrypt (in_decrypt),
    .in_key     (in_key),
    .in_block   (in_block),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Handshakes sampled mid-cycle; inputs only change 2 time units after a rising edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset && in_valid && in_ready) acc_cyc.push_back(cyc);
    if (!reset && out_valid && out_ready) begin
      res_q.push_back(out_block);
      res_cyc.push_back(cyc);
    end
  end

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_logs();
    acc_cyc.delete();
    res_cyc.delete();
    res_q.delete();
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (acc_cyc.size() >= n) break;
    end
    chk_int("accept_seen", acc_cyc.size(), n);
  endtask

  task automatic start_job(input logic [63:0] key, input logic [63:0] blk, input logic dec);
    int n0;
    n0 = acc_cyc.size();
    @(posedge clk); #2;
    in_key = key; in_block = blk; in_decrypt = dec; in_valid = 1'b1;
    wait_acc(n0 + 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 60; i++) begin
      if (res_q.size() >= n) break;
      @(negedge clk); #1;
    end
    chk_int("result_count", res_q.size(), n);
  endtask

  initial begin
    int bad;
    logic [63:0] held;

    vecs[0] = '{key: FipsKey, blk: FipsPt, dec: 1'b0, exp: FipsCt};
    vecs[1] = '{key: FipsKey, blk: FipsCt, dec: 1'b1, exp: FipsPt};
    vecs[2] = '{key: 64'h0E329232EA6D0D73, blk: 64'h8787878787878787, dec: 1'b0,
                exp: 64'h0000000000000000};
    vecs[3] = '{key: 64'h0E329232EA6D0D73, blk: 64'h0000000000000000, dec: 1'b1,
                exp: 64'h8787878787878787};
    vecs[4] = '{key: 64'h0, blk: 64'h0, dec: 1'b0, exp: 64'h8CA64DE9C1B123A7};
    vecs[5] = '{key: '1, blk: '1, dec: 1'b0, exp: 64'h7359B2163E4EDC58};

    reset = 1'b1; in_valid = 1'b0; in_decrypt = 1'b0; out_ready = 1'b1;
    in_key = '0; in_block = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk); #1;
    chk_int("rst_in_ready", int'(in_ready), 1);
    chk_int("rst_out_valid", int'(out_valid), 0);
    chk_int("rst_busy", int'(busy), 0);
    chk64("rst_out_block", out_block, 64'h0);

    // Known-answer table, with latency from accept to first out_valid.
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      start_job(vecs[v].key, vecs[v].blk, vecs[v].dec);
      wait_results(1);
      if (res_q.size() > 0 && acc_cyc.size() > 0) begin
        chk64($sformatf("vec%0d_block", v), res_q[0], vecs[v].exp);
        chk_int($sformatf("vec%0d_latency", v), res_cyc[0] - acc_cyc[0], 17);
      end
    end

    // Backpressure in DONE with an ignored in_valid pulse.
    clear_logs();
    @(posedge clk); #2 out_ready = 1'b0;
    start_job(FipsKey, FipsPt, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (out_valid) break;
    end
    held = out_block;
    chk64("bp_block", held, FipsCt);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      in_valid = (i == 3);
      in_key = 64'hFFFF0000FFFF0000; in_block = 64'h1234;
      @(negedge clk); #1;
      if (!out_valid || out_block !== held || in_ready || !busy) bad++;
    end
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b1;
    chk_int("bp_stable", bad, 0);
    chk_int("bp_no_accept", acc_cyc.size(), 1);
    @(posedge clk); #2;
    chk_int("bp_release_in_ready", int'(in_ready), 1);
    chk_int("bp_release_out_valid", int'(out_valid), 0);
    chk_int("bp_result_count", res_q.size(), 1);

    // Back-to-back jobs with in_valid held high.
    clear_logs();
    @(posedge clk); #2;
    in_key = FipsKey; in_block = FipsPt; in_decrypt = 1'b0; in_valid = 1'b1;
    wait_acc(1);
    @(posedge clk); #2;
    in_key = 64'h0E329232EA6D0D73; in_block = 64'h8787878787878787;
    wait_acc(2);
    @(posedge clk); #2 in_valid = 1'b0;
    wait_results(2);
    if (res_q.size() >= 2 && acc_cyc.size() >= 2) begin
      chk64("b2b_first", res_q[0], FipsCt);
      chk64("b2b_second", res_q[1], 64'h0);
      chk_int("b2b_accept_gap", acc_cyc[1] - acc_cyc[0], 18);
    end

    // Reset during round 8 abandons the job.
    clear_logs();
    start_job(FipsKey, FipsPt, 1'b0);
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    chk_int("mid_rst_in_ready", int'(in_ready), 1);
    chk_int("mid_rst_out_valid", int'(out_valid), 0);
    chk_int("mid_rst_busy", int'(busy), 0);
    chk64("mid_rst_out_block", out_block, 64'h0);
    repeat (25) @(posedge clk);
    chk_int("mid_rst_no_result", res_q.size(), 0);
    start_job(FipsKey, FipsPt, 1'b0);
    wait_results(1);
    if (res_q.size() > 0) chk64("mid_rst_fresh", res_q[0], FipsCt);

    // Inputs scrambled every cycle after accept.
    clear_logs();
    start_job(FipsKey, FipsPt, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      in_key = {$urandom, $urandom}; in_block = {$urandom, $urandom};
      in_decrypt = ~in_decrypt;
      if (res_q.size() > 0) break;
    end
    chk_int("stab_count", res_q.size(), 1);
    if (res_q.size() > 0) chk64("stab_block", res_q[0], FipsCt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
